// File: rtl/dcim_accumulator.sv
// dcim_accumulator: sums VEC_LEN unsigned products per result and queues each
// completed sum in a small first-word fall-through result FIFO.
// Optional feature: define DCIM_ACC_DROP_CNT_EN to add the drop_cnt output,
// a saturating count of results lost to a full FIFO.
module dcim_accumulator #(
  parameter int PROD_WIDTH = 64,
  parameter int ACC_WIDTH  = 72,
  parameter int VEC_LEN    = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init_done,
  input  logic                       in_valid,
  input  logic [PROD_WIDTH-1:0]      in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_WIDTH-1:0]       out_data,
  output logic [$clog2(VEC_LEN)-1:0] vec_idx,
  output logic                       overflow
`ifdef DCIM_ACC_DROP_CNT_EN
  ,
  output logic [15:0]                drop_cnt
`endif
);

  localparam int IDX_W = $clog2(VEC_LEN);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, ACC} state_e;

  state_e                 state_q;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [IDX_W-1:0]       idx_q;
  logic [ACC_WIDTH-1:0]   sum;
  logic                   take, last, push, pop, wr_en, drop;

  logic [ACC_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   full, empty;
  logic                   ovf_q;

  // A product only counts while the array is running; sum is the would-be total.
  assign sum   = acc_q + ACC_WIDTH'(in_data);
  assign take  = (state_q == ACC) && init_done && in_valid;
  assign last  = (idx_q == IDX_W'(VEC_LEN - 1));
  assign push  = take && last;
  assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign pop   = out_ready && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  // Run/idle FSM with the running partial sum and product index.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (init_done) state_q <= ACC;
        end
        ACC: begin
          if (!init_done) begin
            // Array left RUN: partial vector is meaningless, drop it.
            state_q <= IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
          end else if (in_valid) begin
            if (last) begin
              acc_q <= '0;
              idx_q <= '0;
            end else begin
              acc_q <= sum;
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // FIFO pointer/occupancy next state.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (wr_en) wr_d = wr_q + 1'b1;
    if (pop)   rd_d = rd_q + 1'b1;
    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO pointer/occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // FIFO storage; contents are don't-care until written since empty masks the head.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= sum;
  end

  // Sticky overflow: only reset clears it.
  always_ff @(posedge clk) begin
    if (rst)       ovf_q <= 1'b0;
    else if (drop) ovf_q <= 1'b1;
  end

`ifdef DCIM_ACC_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of dropped results.
  always_ff @(posedge clk) begin
    if (rst)                               drop_cnt_q <= '0;
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem_q[rd_q];
  assign vec_idx   = idx_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/dcim_accumulator.md
DCIM_ACCUMULATOR -- requirements
Module: dcim_accumulator

Interface
REQ-001 SHALL have parameter PROD_WIDTH, default 64, meaning width of each incoming product word.
REQ-002 SHALL have parameter ACC_WIDTH, default 72, meaning width of the accumulator and of each result word.
REQ-003 SHALL have parameter VEC_LEN, default 64, meaning number of products summed per result (one full address sweep).
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning result FIFO entries (power of two).
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port init_done, input, 1, multiplier array is in RUN and products are meaningful.
REQ-008 SHALL have port in_valid, input, 1, in_data carries a product this cycle (no ready; upstream cannot stall).
REQ-009 SHALL have port in_data, input, PROD_WIDTH, unsigned product.
REQ-010 SHALL have port out_valid, input/output handshake: output, 1, FIFO head holds a result.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts the head when out_valid and out_ready are both high.
REQ-012 SHALL have port out_data, output, ACC_WIDTH, FIFO head result (first-word fall-through).
REQ-013 SHALL have port vec_idx, output, log2(VEC_LEN), count of products accumulated into the current partial sum.
REQ-014 SHALL have port overflow, output, 1, sticky flag set when a completed result is dropped because the FIFO is full.

Function
REQ-015 SHALL implement states IDLE and ACC; IDLE->ACC when init_done=1; ACC->IDLE when init_done=0.
REQ-016 SHALL, on the ACC->IDLE transition, discard the partial sum and clear vec_idx to 0, retaining FIFO contents.
REQ-017 SHALL ignore in_valid in IDLE.
REQ-018 SHALL, in ACC with in_valid=1 and vec_idx<VEC_LEN-1, set acc<=acc+zero-extended in_data and increment vec_idx.
REQ-019 SHALL, in ACC with in_valid=1 and vec_idx=VEC_LEN-1, push acc+in_data into the FIFO, clear acc to 0, and wrap vec_idx to 0 in the same cycle, with no bubble.
REQ-020 SHALL wrap arithmetic modulo 2^ACC_WIDTH; the defaults cannot overflow (64 x (2^64-1) < 2^72).
REQ-021 SHALL assert out_valid the cycle after the last product of a vector is accepted (latency 1 from final in_valid to out_valid).
REQ-022 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL, on a simultaneous push and pop with the FIFO full, accept both (occupancy unchanged) with no drop.
REQ-024 SHALL, on a push with the FIFO full and no pop, drop the result, set overflow, and leave FIFO contents unchanged.
REQ-025 SHALL, on a pop with the FIFO empty, do nothing, with out_valid remaining 0.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, set state IDLE, acc=0, vec_idx=0, FIFO empty, out_valid=0, out_data=0, overflow=0; this reset takes priority over all other events, including mid-vector.
REQ-027 SHALL clear overflow only by rst.

Configuration
REQ-028 SHALL, with macro DCIM_ACC_DROP_CNT_EN defined, add output drop_cnt[15:0], which increments on each dropped result, saturates at 16'hFFFF, and is reset to 0 by rst.
REQ-029 SHALL, with DCIM_ACC_DROP_CNT_EN undefined, omit the drop_cnt port and its register entirely; all other behaviour is identical.

Verification
REQ-030 SHALL cover: init_done=1 with 64 consecutive in_valid of in_data=3 and out_ready=1 -> one result 192, out_valid one cycle after the 64th product.
REQ-031 SHALL cover: 64 products of 64'hFFFF_FFFF_FFFF_FFFF -> out_data = 72'h3F_FFFF_FFFF_FFFF_FFC0.
REQ-032 SHALL cover: out_ready=0 with 6 back-to-back vectors of value 1 -> FIFO holds four results of 64, the 5th and 6th are dropped, overflow=1, and drop_cnt=2 when the macro is enabled.
REQ-033 SHALL cover: init_done dropped after 10 products, then restored, then 64 products of 1 -> single result 64, with the partial sum of 10 discarded.
REQ-034 SHALL cover: rst pulsed for 1 cycle mid-vector with 2 results queued -> out_valid=0, vec_idx=0, overflow=0, and the next full vector yields a correct sum.
REQ-035 SHALL cover: FIFO full with out_ready=1 on the same cycle as a push -> no drop, 4 entries retained, results in order.
